// File: rtl/alu_core.sv
// alu_core: dual-mode 8-bit logic ALU with registered result and sticky IRQ.
// Ports: clk, alu_rst (sync, active-high), alu_in_a/alu_in_b operands,
//   alu_op_a/alu_op_b opcodes, alu_enable/_a/_b mode enables,
//   alu_irq_clr IRQ clear; outputs alu_out result, alu_irq sticky
//   interrupt, alu_err illegal-enable flag (only with ALU_ILLEGAL_ERR_EN).
module alu_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              alu_rst,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  input  logic [1:0]        alu_op_a,
  input  logic [1:0]        alu_op_b,
  input  logic              alu_enable,
  input  logic              alu_enable_a,
  input  logic              alu_enable_b,
  input  logic              alu_irq_clr,
`ifdef ALU_ILLEGAL_ERR_EN
  output logic              alu_err,
`endif
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN_A,
    S_RUN_B,
    S_ERR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] out_d;
  logic              irq_q;
  logic              irq_d;
  logic              err_q;
  logic              err_d;

  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;
  logic              trig_a;
  logic              trig_b;
  logic              trig;

  // Next mode depends only on the enables sampled at this edge.
  always_comb begin
    state_d = S_IDLE;
    if (alu_enable) begin
      unique case ({alu_enable_a, alu_enable_b})
        2'b10:   state_d = S_RUN_A;
        2'b01:   state_d = S_RUN_B;
`ifdef ALU_ILLEGAL_ERR_EN
        2'b11:   state_d = S_ERR;
`else
        2'b11:   state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    res_a  = '0;
    trig_a = 1'b0;
    unique case (alu_op_a)
      2'd0: begin
        res_a  = alu_in_a & alu_in_b;
        trig_a = (res_a == DATA_W'(8'hFF));
      end
      2'd1: begin
        res_a  = ~(alu_in_a & alu_in_b);
        trig_a = (res_a == DATA_W'(8'h00));
      end
      2'd2: begin
        res_a  = alu_in_a | alu_in_b;
        trig_a = (res_a == DATA_W'(8'hF8));
      end
      default: begin
        res_a  = alu_in_a ^ alu_in_b;
        trig_a = (res_a == DATA_W'(8'h83));
      end
    endcase
  end

  always_comb begin
    res_b  = '0;
    trig_b = 1'b0;
    unique case (alu_op_b)
      2'd0: begin
        res_b  = ~(alu_in_a ^ alu_in_b);
        trig_b = (res_b == DATA_W'(8'hF1));
      end
      2'd1: begin
        res_b  = alu_in_a & alu_in_b;
        trig_b = (res_b == DATA_W'(8'hF4));
      end
      2'd2: begin
        res_b  = ~(alu_in_a | alu_in_b);
        trig_b = (res_b == DATA_W'(8'hF5));
      end
      default: begin
        res_b  = alu_in_a | alu_in_b;
        trig_b = (res_b == DATA_W'(8'hFF));
      end
    endcase
  end

  // Result loads only in a run mode; IDLE and ERR hold.
  always_comb begin
    out_d = out_q;
    trig  = 1'b0;
    unique case (state_d)
      S_RUN_A: begin
        out_d = res_a;
        trig  = trig_a;
      end
      S_RUN_B: begin
        out_d = res_b;
        trig  = trig_b;
      end
      default: begin
        out_d = out_q;
        trig  = 1'b0;
      end
    endcase
  end

  // Clear beats a simultaneous trigger.
  always_comb begin
    irq_d = irq_q;
    if (alu_irq_clr) begin
      irq_d = 1'b0;
    end else if (trig) begin
      irq_d = 1'b1;
    end
  end

  assign err_d = (state_d == S_ERR);

  always_ff @(posedge clk) begin
    if (alu_rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  assign alu_out = out_q;
  assign alu_irq = irq_q;

`ifdef ALU_ILLEGAL_ERR_EN
  assign alu_err = err_q;
  logic state_unused;
  assign state_unused = ^state_q;
`else
  logic state_unused;
  assign state_unused = ^{state_q, err_q};
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed table-driven bench for alu_core.
// Vectors hold inputs and the expected outputs after the next edge.
module tb_alu_core;

  logic       clk;
  logic       alu_rst;
  logic [7:0] alu_in_a;
  logic [7:0] alu_in_b;
  logic [1:0] alu_op_a;
  logic [1:0] alu_op_b;
  logic       alu_enable;
  logic       alu_enable_a;
  logic       alu_enable_b;
  logic       alu_irq_clr;
  logic [7:0] alu_out;
  logic       alu_irq;
`ifdef ALU_ILLEGAL_ERR_EN
  logic       alu_err;
`endif

  int n_cmp;
  int n_bad;

  alu_core #(.DATA_W(8)) dut (
    .clk          (clk),
    .alu_rst      (alu_rst),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_enable   (alu_enable),
    .alu_enable_a (alu_enable_a),
    .alu_enable_b (alu_enable_b),
    .alu_irq_clr  (alu_irq_clr),
`ifdef ALU_ILLEGAL_ERR_EN
    .alu_err      (alu_err),
`endif
    .alu_out      (alu_out),
    .alu_irq      (alu_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       en;
    logic       ea;
    logic       eb;
    logic [1:0] opa;
    logic [1:0] opb;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic       ei;
    logic       ee;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rst, input logic clr,
    input logic en, input logic ea, input logic eb,
    input logic [1:0] opa, input logic [1:0] opb,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] eo, input logic ei, input logic ee);
    vec_t t;
    t.rst = rst; t.clr = clr;
    t.en = en; t.ea = ea; t.eb = eb;
    t.opa = opa; t.opb = opb;
    t.a = a; t.b = b;
    t.eo = eo; t.ei = ei; t.ee = ee;
    vq.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    alu_rst      = t.rst;
    alu_irq_clr  = t.clr;
    alu_enable   = t.en;
    alu_enable_a = t.ea;
    alu_enable_b = t.eb;
    alu_op_a     = t.opa;
    alu_op_b     = t.opb;
    alu_in_a     = t.a;
    alu_in_b     = t.b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input vec_t t);
    chk({nm, "_out"}, idx, alu_out, t.eo);
    chk({nm, "_irq"}, idx, {7'd0, alu_irq}, {7'd0, t.ei});
`ifdef ALU_ILLEGAL_ERR_EN
    chk({nm, "_err"}, idx, {7'd0, alu_err}, {7'd0, t.ee});
`endif
  endtask

  initial begin
    vec_t t;
    n_cmp = 0;
    n_bad = 0;
    t = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
          8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    drive(t);

    // rst clr en ea eb opa opb a b | out irq err
    add(1, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0, 8'hF0, 8'h3C, 8'h30, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 8'hF0, 8'h3C, 8'hCF, 0, 0);
    add(0, 0, 1, 1, 0, 2, 0, 8'hF0, 8'h3C, 8'hFC, 0, 0);
    add(0, 0, 1, 1, 0, 3, 0, 8'hF0, 8'h3C, 8'hCC, 0, 0);
    add(0, 0, 1, 1, 0, 2, 0, 8'hF8, 8'h00, 8'hF8, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hF8, 0, 0);
    add(0, 0, 1, 0, 1, 0, 2, 8'h0A, 8'h00, 8'hF5, 1, 0);
    add(0, 0, 1, 0, 1, 0, 3, 8'h01, 8'h02, 8'h03, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 8'h0F, 8'hF0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 8'hF4, 8'hFF, 8'hF4, 1, 0);
    add(0, 1, 1, 1, 0, 1, 0, 8'hFF, 8'hFF, 8'h00, 0, 0);
    add(0, 0, 1, 1, 0, 1, 0, 8'hFF, 8'hFF, 8'h00, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 8'h0E, 8'h00, 8'hF1, 1, 0);
    add(0, 0, 1, 1, 0, 3, 0, 8'hC0, 8'h03, 8'hC3, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      step();
      chk_all("vec", i, vq[i]);
    end

    // Idle hold with scrambled operands.
    for (int i = 0; i < 5; i++) begin
      t = '{1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom),
            2'($urandom), 2'($urandom),
            8'($urandom), 8'($urandom), 8'hC3, 1'b1, 1'b0};
      drive(t);
      step();
      chk_all("idle", i, t);
    end

    // Illegal enables after loading 5A.
    t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd3,
          8'h50, 8'h0A, 8'h5A, 1'b1, 1'b0};
    drive(t);
    step();
    chk_all("ld5a", 0, t);
    for (int i = 0; i < 3; i++) begin
      t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3,
            8'hFF, 8'hFF, 8'h5A, 1'b1, 1'b1};
      drive(t);
      step();
      chk_all("illeg", i, t);
    end
    t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0,
          8'hFF, 8'hFF, 8'h5A, 1'b1, 1'b0};
    drive(t);
    step();
    chk_all("errx", 0, t);

    // Reset overrides an in-flight op; first edge after is live.
    t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0,
          8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    drive(t);
    step();
    chk_all("rst2", 0, t);
    t = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0,
          8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    drive(t);
    step();
    chk_all("post", 0, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
